// File: rtl/uart_pkg.sv
// Shared UART constants: default bit period, 8N1 frame shape and the
// transmit serializer state encoding.
package uart_pkg;

  localparam int BAUD_SET_COUNTER_DEF = 10416;  // 100 MHz / 9600 bps, truncated
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered full/empty/level flags and a
// sticky overflow flag; shared by the UART transmit and receive paths.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             overflow
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  always_comb begin
    // Flags are from the start of the cycle, so a push while full is refused
    // even if a pop frees a slot on the same edge.
    push       = wr_en && !full_q;
    pop        = rd_en && !empty_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    full_d     = (level_d == (AW+1)'(DEPTH));
    empty_d    = (level_d == '0);
    overflow_d = overflow_q || (wr_en && full_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Head is read combinationally so the consumer can pop and load on one edge.
  assign rd_data  = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are
// serialized LSB first on a registered, glitch-free txd line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_SET_COUNTER = BAUD_SET_COUNTER_DEF,
  parameter int FIFO_AW          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] level,
  output logic             overflow,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = $clog2(BAUD_SET_COUNTER);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_SET_COUNTER - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;

  logic                 fifo_rd_en;
  logic [7:0]           fifo_rd_data;
  logic                 fifo_empty;
  logic                 baud_last;

  uart_sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (fifo_rd_en),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (fifo_empty),
    .level    (level),
    .overflow (overflow)
  );

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  // txd_d is the line level of the *next* state, so txd changes on the same
  // edge as the state and never passes through combinational decode.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = fifo_rd_data;
          state_d    = START;
          txd_d      = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          txd_d      = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = STOP;
            bit_idx_d = '0;
            txd_d     = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          txd_d      = 1'b1;
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_d == STOP) && (baud_cnt_d == BAUD_LAST) &&
                (bit_idx_d == 3'(STOP_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign empty   = fifo_empty;
  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule
